// File: rtl/atm_pkg.sv
// Shared types for the ATM session controller: FSM states, command opcodes,
// response status codes and a small width helper.
package atm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LANG,
    ST_AUTH,
    ST_HOME,
    ST_EXEC,
    ST_RESP
  } state_t;

  typedef enum logic [2:0] {
    OP_WITHDRAW = 3'd0,
    OP_DEPOSIT  = 3'd1,
    OP_BALANCE  = 3'd2,
    OP_TRANSFER = 3'd3,
    OP_CHPIN    = 3'd4
  } op_t;

  typedef enum logic [2:0] {
    RS_OK           = 3'd0,
    RS_INSUFFICIENT = 3'd1,
    RS_OVERFLOW     = 3'd2,
    RS_BAD_DEST     = 3'd3,
    RS_BAD_OP       = 3'd4,
    RS_ZERO_AMT     = 3'd5
  } status_t;

  // Account-id width; a single-account build still gets a 1-bit id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/atm_session_ctrl_if.sv
// Front-panel / keypad / display bundle of the ATM session controller.
// master = panel side driving requests, slave = the controller.
interface atm_session_ctrl_if
  import atm_pkg::*;
#(
  parameter int NUM_ACC = 4,
  parameter int PIN_W   = 4,
  parameter int BAL_W   = 8,
  parameter int AMT_W   = 6
);
  localparam int ID_W = id_width(NUM_ACC);

  logic              card_in;
  logic              lang_ok;
  logic              exit_req;
  logic              auth_valid;
  logic [ID_W-1:0]   acc_id;
  logic [PIN_W-1:0]  pin;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [AMT_W-1:0]  cmd_amt;
  logic [ID_W-1:0]   cmd_dest;
  logic [PIN_W-1:0]  cmd_newpin;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2:0]        rsp_status;
  logic [BAL_W-1:0]  rsp_balance;
  logic              auth_ok;
  logic              auth_fail;
  logic              card_eject;
  logic              session_active;

  modport master (
    output card_in, lang_ok, exit_req, auth_valid, acc_id, pin,
           cmd_valid, cmd_op, cmd_amt, cmd_dest, cmd_newpin, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_status, rsp_balance,
           auth_ok, auth_fail, card_eject, session_active
  );

  modport slave (
    input  card_in, lang_ok, exit_req, auth_valid, acc_id, pin,
           cmd_valid, cmd_op, cmd_amt, cmd_dest, cmd_newpin, rsp_ready,
    output cmd_ready, rsp_valid, rsp_status, rsp_balance,
           auth_ok, auth_fail, card_eject, session_active
  );

endinterface

// File: rtl/atm_acct_store.sv
// Account store: PIN, balance and lock flag per account. Reads are
// combinational; writes land on the clock edge. Two balance write ports let a
// transfer debit and credit in the same cycle.
module atm_acct_store #(
  parameter int NUM_ACC  = 4,
  parameter int PIN_W    = 4,
  parameter int BAL_W    = 8,
  parameter int INIT_BAL = 40,
  parameter int ID_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ID_W-1:0]  rd_addr_a,
  input  logic [ID_W-1:0]  rd_addr_b,
  output logic [PIN_W-1:0] rd_pin_a,
  output logic [BAL_W-1:0] rd_bal_a,
  output logic             rd_lock_a,
  output logic [BAL_W-1:0] rd_bal_b,
  input  logic [ID_W-1:0]  wr_addr_a,
  input  logic             bal_we_a,
  input  logic [BAL_W-1:0] bal_wd_a,
  input  logic [ID_W-1:0]  wr_addr_b,
  input  logic             bal_we_b,
  input  logic [BAL_W-1:0] bal_wd_b,
  input  logic             pin_we,
  input  logic [PIN_W-1:0] pin_wd,
  input  logic             lock_we,
  input  logic [ID_W-1:0]  lock_addr
);
  logic [PIN_W-1:0] pin_mem  [NUM_ACC];
  logic [BAL_W-1:0] bal_mem  [NUM_ACC];
  logic             lock_mem [NUM_ACC];

  assign rd_pin_a  = pin_mem[rd_addr_a];
  assign rd_bal_a  = bal_mem[rd_addr_a];
  assign rd_lock_a = lock_mem[rd_addr_a];
  assign rd_bal_b  = bal_mem[rd_addr_b];

  // Reset loads default PINs (pin k = k) and balances; writes apply on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_ACC; k++) begin
        pin_mem[k]  <= PIN_W'(k);
        bal_mem[k]  <= BAL_W'(INIT_BAL);
        lock_mem[k] <= 1'b0;
      end
    end else begin
      if (bal_we_a) bal_mem[wr_addr_a] <= bal_wd_a;
      if (bal_we_b) bal_mem[wr_addr_b] <= bal_wd_b;
      if (pin_we)   pin_mem[wr_addr_a] <= pin_wd;
      if (lock_we)  lock_mem[lock_addr] <= 1'b1;
    end
  end

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card/language/PIN login with per-account lockout,
// then one command at a time through EXEC/RESP against the account store.
//
// state | meaning
// IDLE  | no card, waiting for card_in
// LANG  | card inserted, waiting for language choice
// AUTH  | waiting for account id + PIN
// HOME  | logged in, ready for a command, inactivity timer running
// EXEC  | evaluate latched command, store updates at end of cycle
// RESP  | hold response until rsp_ready
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int NUM_ACC     = 4,
  parameter int PIN_W       = 4,
  parameter int BAL_W       = 8,
  parameter int AMT_W       = 6,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000,
  parameter int INIT_BAL    = 40
) (
  input logic               clk,
  input logic               rst,
  atm_session_ctrl_if.slave bus
);
  localparam int ID_W = id_width(NUM_ACC);
  localparam int FC_W = $clog2(MAX_TRIES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(MAX_TRIES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [FC_W-1:0]  fail_cnt;
  logic [TO_W-1:0]  tcnt;
  logic [ID_W-1:0]  sess_acc, dest_q;
  logic [2:0]       op_q;
  logic [AMT_W-1:0] amt_q;
  logic [PIN_W-1:0] newpin_q;
  logic             exit_pend;
  logic             cmd_ready_q, rsp_valid_q, auth_ok_q, auth_fail_q;
  logic             card_eject_q, session_q;
  status_t          rsp_status_q;
  logic [BAL_W-1:0] rsp_balance_q;

  logic             exit_ev, acc_in, auth_match, lock_we;
  logic [ID_W-1:0]  rd_addr_a;
  logic [PIN_W-1:0] rd_pin_a;
  logic [BAL_W-1:0] rd_bal_a, rd_bal_b;
  logic             rd_lock_a;
  logic [31:0]      acc_ext, dest_ext;
  logic [BAL_W:0]   amt_x, src_sum, dst_sum;
  status_t          ev_status;
  logic [BAL_W-1:0] ev_src, ev_dst;
  logic             we_a, we_b, pin_we;

  // Pulling the card is handled exactly like pressing exit.
  assign exit_ev    = bus.exit_req || !bus.card_in;
  assign acc_ext    = 32'(bus.acc_id);
  assign dest_ext   = 32'(dest_q);
  assign acc_in     = acc_ext < 32'(NUM_ACC);
  assign rd_addr_a  = (state == ST_AUTH) ? bus.acc_id : sess_acc;
  assign auth_match = acc_in && !rd_lock_a && (rd_pin_a == bus.pin);
  assign lock_we    = (state == ST_AUTH) && bus.auth_valid && !exit_ev &&
                      !auth_match && acc_in && (fail_cnt == FC_LAST);
  assign amt_x      = (BAL_W+1)'(amt_q);
  assign src_sum    = {1'b0, rd_bal_a} + amt_x;
  assign dst_sum    = {1'b0, rd_bal_b} + amt_x;

  atm_acct_store #(
    .NUM_ACC(NUM_ACC), .PIN_W(PIN_W), .BAL_W(BAL_W),
    .INIT_BAL(INIT_BAL), .ID_W(ID_W)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (dest_q),
    .rd_pin_a  (rd_pin_a),
    .rd_bal_a  (rd_bal_a),
    .rd_lock_a (rd_lock_a),
    .rd_bal_b  (rd_bal_b),
    .wr_addr_a (sess_acc),
    .bal_we_a  (we_a && (state == ST_EXEC)),
    .bal_wd_a  (ev_src),
    .wr_addr_b (dest_q),
    .bal_we_b  (we_b && (state == ST_EXEC)),
    .bal_wd_b  (ev_dst),
    .pin_we    (pin_we && (state == ST_EXEC)),
    .pin_wd    (newpin_q),
    .lock_we   (lock_we),
    .lock_addr (bus.acc_id)
  );

  // Evaluate the latched command; any non-OK status leaves all write enables low.
  always_comb begin
    ev_status = RS_OK;
    ev_src    = rd_bal_a;
    ev_dst    = rd_bal_b;
    we_a      = 1'b0;
    we_b      = 1'b0;
    pin_we    = 1'b0;
    case (op_q)
      OP_WITHDRAW: begin
        if (amt_q == '0)                   ev_status = RS_ZERO_AMT;
        else if (amt_x > {1'b0, rd_bal_a}) ev_status = RS_INSUFFICIENT;
        else begin
          we_a   = 1'b1;
          ev_src = rd_bal_a - amt_x[BAL_W-1:0];
        end
      end
      OP_DEPOSIT: begin
        if (amt_q == '0)        ev_status = RS_ZERO_AMT;
        else if (src_sum[BAL_W]) ev_status = RS_OVERFLOW;
        else begin
          we_a   = 1'b1;
          ev_src = src_sum[BAL_W-1:0];
        end
      end
      OP_BALANCE: ev_status = RS_OK;
      OP_TRANSFER: begin
        if (dest_q == sess_acc || dest_ext >= 32'(NUM_ACC)) ev_status = RS_BAD_DEST;
        else if (amt_x > {1'b0, rd_bal_a})                  ev_status = RS_INSUFFICIENT;
        else if (dst_sum[BAL_W])                            ev_status = RS_OVERFLOW;
        else begin
          we_a   = 1'b1;
          we_b   = 1'b1;
          ev_src = rd_bal_a - amt_x[BAL_W-1:0];
          ev_dst = dst_sum[BAL_W-1:0];
        end
      end
      OP_CHPIN: pin_we = 1'b1;
      default:  ev_status = RS_BAD_OP;
    endcase
  end

  // Session FSM with registered level outputs and one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      fail_cnt      <= '0;
      tcnt          <= '0;
      sess_acc      <= '0;
      dest_q        <= '0;
      op_q          <= '0;
      amt_q         <= '0;
      newpin_q      <= '0;
      exit_pend     <= 1'b0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      auth_ok_q     <= 1'b0;
      auth_fail_q   <= 1'b0;
      card_eject_q  <= 1'b0;
      session_q     <= 1'b0;
      rsp_status_q  <= RS_OK;
      rsp_balance_q <= '0;
    end else begin
      auth_ok_q    <= 1'b0;
      auth_fail_q  <= 1'b0;
      card_eject_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.card_in) state <= ST_LANG;
        end
        ST_LANG: begin
          if (exit_ev) begin
            state        <= ST_IDLE;
            card_eject_q <= 1'b1;
          end else if (bus.lang_ok) begin
            state <= ST_AUTH;
          end
        end
        ST_AUTH: begin
          if (exit_ev) begin
            state        <= ST_IDLE;
            card_eject_q <= 1'b1;
            fail_cnt     <= '0;
          end else if (bus.auth_valid) begin
            if (auth_match) begin
              state       <= ST_HOME;
              sess_acc    <= bus.acc_id;
              fail_cnt    <= '0;
              tcnt        <= '0;
              auth_ok_q   <= 1'b1;
              cmd_ready_q <= 1'b1;
              session_q   <= 1'b1;
            end else begin
              auth_fail_q <= 1'b1;
              if (fail_cnt == FC_LAST) begin
                state        <= ST_IDLE;
                card_eject_q <= 1'b1;
                fail_cnt     <= '0;
              end else begin
                fail_cnt <= fail_cnt + 1'b1;
              end
            end
          end
        end
        ST_HOME: begin
          if (exit_ev || exit_pend || (!bus.cmd_valid && tcnt == TO_LAST)) begin
            state        <= ST_IDLE;
            card_eject_q <= 1'b1;
            cmd_ready_q  <= 1'b0;
            session_q    <= 1'b0;
            exit_pend    <= 1'b0;
            tcnt         <= '0;
          end else if (bus.cmd_valid) begin
            state       <= ST_EXEC;
            op_q        <= bus.cmd_op;
            amt_q       <= bus.cmd_amt;
            dest_q      <= bus.cmd_dest;
            newpin_q    <= bus.cmd_newpin;
            tcnt        <= '0;
            cmd_ready_q <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_EXEC: begin
          if (exit_ev) exit_pend <= 1'b1;
          state         <= ST_RESP;
          rsp_valid_q   <= 1'b1;
          rsp_status_q  <= ev_status;
          rsp_balance_q <= we_a ? ev_src : rd_bal_a;
        end
        ST_RESP: begin
          if (exit_ev) exit_pend <= 1'b1;
          if (bus.rsp_ready) begin
            state       <= ST_HOME;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            tcnt        <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready      = cmd_ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_status     = rsp_status_q;
  assign bus.rsp_balance    = rsp_balance_q;
  assign bus.auth_ok        = auth_ok_q;
  assign bus.auth_fail      = auth_fail_q;
  assign bus.card_eject     = card_eject_q;
  assign bus.session_active = session_q;

endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
- Parametrised multi-account ATM session controller, successor to the single-FSM ATM top.
- Handles card/language/PIN authentication with per-account lockout, then a command/response handshake for five operations: withdraw, deposit, balance, transfer, change-PIN.
- Adds width and account-count parameters, an inactivity timeout and explicit status codes.
- Holds the account store (PINs, balances, lock flags); sits between the front-panel/keypad logic and the display/dispenser logic.

Parameters:
NUM_ACC, 4, number of accounts; account id k is index k
PIN_W, 4, PIN width
BAL_W, 8, balance width (unsigned)
AMT_W, 6, request amount width
MAX_TRIES, 3, consecutive PIN failures per session before lockout
TIMEOUT_CYC, 1000, idle cycles in HOME before forced logout
INIT_BAL, 40, balance of every account after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
card_in  in  1  card inserted (level)
lang_ok  in  1  language chosen (pulse)
exit_req  in  1  user exit (pulse)
auth_valid  in  1  acc_id/pin present
acc_id  in  $clog2(NUM_ACC)  account id
pin  in  PIN_W  entered PIN
cmd_valid  in  1  command request
cmd_ready  out  1  high only in HOME
cmd_op  in  3  0 withdraw, 1 deposit, 2 balance, 3 transfer, 4 change-PIN
cmd_amt  in  AMT_W  amount
cmd_dest  in  $clog2(NUM_ACC)  transfer destination
cmd_newpin  in  PIN_W  new PIN
rsp_valid  out  1  response held until rsp_ready
rsp_ready  in  1  response consumed
rsp_status  out  3  0 OK, 1 INSUFFICIENT, 2 OVERFLOW, 3 BAD_DEST, 4 BAD_OP, 5 ZERO_AMT
rsp_balance  out  BAL_W  session account balance after the operation
auth_ok  out  1  one-cycle pulse on successful login
auth_fail  out  1  one-cycle pulse on each failed attempt
card_eject  out  1  one-cycle pulse on every return to IDLE from a session
session_active  out  1  high in HOME, EXEC, RESP

Behaviour:
- Reset: state IDLE; all outputs 0; pin[k]=k; balance[k]=INIT_BAL; lock[k]=0; fail_cnt=0; timeout count=0. Reset mid-operation aborts with no partial update.
- States: IDLE, LANG, AUTH, HOME, EXEC, RESP.
- IDLE -> LANG when card_in=1.
- LANG -> AUTH on lang_ok.
- AUTH:
  - On auth_valid with pin==pin[acc_id] and !lock[acc_id]: latch acc_id as sess_acc, clear fail_cnt, pulse auth_ok, go to HOME next cycle.
  - Otherwise pulse auth_fail and increment fail_cnt. A locked account always fails.
  - If fail_cnt reaches MAX_TRIES: set lock[acc_id], go to IDLE, pulse card_eject.
- HOME:
  - cmd_ready=1. A command is accepted when cmd_valid&&cmd_ready; its fields are latched and the FSM goes to EXEC.
  - The timeout count increments each HOME cycle with no accepted command and clears on acceptance.
  - At TIMEOUT_CYC -> IDLE with card_eject.
- EXEC (one cycle): evaluate the latched command; the store updates at the end of this cycle; then go to RESP.
  - Withdraw: amt==0 gives ZERO_AMT; amt>bal gives INSUFFICIENT; otherwise bal-=amt. Withdrawing the exact balance leaves 0 with status OK.
  - Deposit: amt==0 gives ZERO_AMT; a sum exceeding 2^BAL_W-1 gives OVERFLOW with no change.
  - Balance: no change, OK.
  - Transfer: dest==sess_acc or dest>=NUM_ACC gives BAD_DEST; then the insufficient check, then the destination overflow check. Source and destination update atomically, or not at all.
  - Change-PIN: pin[sess_acc]=newpin, OK.
  - cmd_op>4 gives BAD_OP.
  - Any non-OK status leaves the store unchanged.
- RESP:
  - rsp_valid=1; rsp_status and rsp_balance are stable until rsp_ready.
  - The cycle after the rsp_valid&&rsp_ready handshake, the FSM returns to HOME.
- Command latency: acceptance at cycle t gives rsp_valid at t+2.
- exit_req:
  - In LANG, AUTH or HOME: go to IDLE next cycle with card_eject.
  - In EXEC or RESP: remembered and honoured on return to HOME.
  - exit_req has priority over a simultaneous auth_valid or cmd_valid.
- card_in dropping outside IDLE is treated as exit_req.
- Lock flags persist across sessions; only rst clears them.

Decomposition:
- Shared package atm_pkg: state enum, op encodings, status codes.
- Sub-module atm_acct_store: PIN/balance/lock arrays with a combinational read port and a registered dual-write port (needed for transfer).

Test Plan:
- Login acc 2, PIN 2; withdraw 15 -> auth_ok; rsp at +2 cycles with OK, balance 25.
- Login acc 1 with a wrong PIN three times -> three auth_fail pulses, card_eject, lock[1]=1; a later correct PIN 1 still gives auth_fail.
- Acc 0, deposit 63 three times (40+189=229), then 30 -> OK, OK, OK, then OVERFLOW with balance 229.
- Acc 3 transfer 40 to acc 1 -> OK, balance 0; re-login acc 1 and query balance -> 80. Transfer to self -> BAD_DEST.
- Change-PIN acc 0 to 9, exit, re-login with PIN 0 -> fail; with PIN 9 -> ok. With TIMEOUT_CYC=8, idle in HOME 8 cycles -> card_eject.
- Hold rsp_ready low 5 cycles with exit_req during RESP -> rsp fields stable; after the handshake, HOME for one cycle, then IDLE.
